// File: rtl/microc_param_stack_pkg.sv
// Shared definitions for the parametrised microcontroller datapath.
//
// Contents:
//   ALU_*     3-bit ALU operation codes, as driven on the op port by the control unit.
//   *_LSB     bit offsets of the fields inside the fixed 16-bit instruction word.
//   NREGS     number of registers in the register file (r0 is hardwired to zero).
package microc_param_stack_pkg;

   localparam logic [2:0] ALU_PASSA = 3'b000;  // A
   localparam logic [2:0] ALU_NOTA  = 3'b001;  // ~A
   localparam logic [2:0] ALU_ADD   = 3'b010;  // A + B
   localparam logic [2:0] ALU_SUB   = 3'b011;  // A - B
   localparam logic [2:0] ALU_AND   = 3'b100;  // A & B
   localparam logic [2:0] ALU_OR    = 3'b101;  // A | B
   localparam logic [2:0] ALU_NEGA  = 3'b110;  // -A
   localparam logic [2:0] ALU_NEGB  = 3'b111;  // -B

   localparam int INSTR_W = 16;
   localparam int OPC_LSB = 10;  // opcode = instr[15:10]
   localparam int RA1_LSB = 8;   // ra1    = instr[11:8]
   localparam int RA2_LSB = 4;   // ra2    = instr[7:4]
   localparam int WA3_LSB = 0;   // wa3    = instr[3:0]
   localparam int IMM_LSB = 4;   // imm    = instr[11:4]

   localparam int NREGS = 16;

endpackage

// File: rtl/microc_param_stack_ret_stack.sv
// Hardware return-address stack.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-low reset (empties the stack)
//   push         call: store wdata on top of the stack
//   pop          return: discard the top entry
//   push & pop   swap: replace the top entry with wdata, depth unchanged
//   wdata [PW]   return address to store
//   top   [PW]   current top entry (meaningless while empty)
//   full, empty  occupancy status
//   ovf, unf     sticky: push while full / pop (or swap) while empty; cleared only by reset
//
// The pointer has DEPTH+1 states so that full and empty are distinct without
// a separate flag: sp counts stored entries, top lives at mem[sp-1].
module microc_param_stack_ret_stack #(
   parameter int PW    = 10,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [PW-1:0] wdata,
   output logic [PW-1:0] top,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;

   logic [SW-1:0] sp;
   logic [PW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;

   assign wr_idx  = sp[AW-1:0];
   // When full, sp[AW-1:0] is 0 and the subtraction wraps to DEPTH-1, which is correct.
   assign top_idx = sp[AW-1:0] - AW'(1);
   assign full    = (sp == SW'(DEPTH));
   assign empty   = (sp == '0);
   assign top     = mem[top_idx];

   always_ff @(posedge clk) begin
      if (!reset) begin
         sp  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (push && !pop) begin
            if (full) ovf <= 1'b1;
            else      sp  <= sp + SW'(1);
         end else if (pop && !push) begin
            if (empty) unf <= 1'b1;
            else       sp  <= sp - SW'(1);
         end else if (push && pop) begin
            if (empty) unf <= 1'b1;
         end
      end
   end

   // Storage is not reset; only the pointer decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !pop && !full)
         mem[wr_idx] <= wdata;
      else if (push && pop && !empty)
         mem[top_idx] <= wdata;
   end

endmodule

// File: rtl/microc_param_stack.sv
// Parametrised single-cycle microcontroller datapath with carry flag,
// hardwired-zero r0 and a hardware call/return stack.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   instr [16]        instruction word at instr_addr (combinational program memory)
//   instr_addr [PW]   current PC
//   s_inc             1: PC+1; 0: jump to tgt, or return / call / swap
//   s_inm             1: ALU A = zero-extended imm, B read from wa3
//   s_push, s_pop     call / return / swap (only when s_inc=0)
//   we3, wez, wec     register-file write, zero-flag and carry-flag update enables
//   op [3]            ALU operation
//   opcode [6]        instr[15:10] for the external control unit
//   z, c              zero and carry flags
//   stk_ovf, stk_unf  sticky stack overflow / underflow
module microc_param_stack
   import microc_param_stack_pkg::*;
#(
   parameter int DW    = 8,
   parameter int PW    = 10,
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   output logic [PW-1:0]      instr_addr,
   input  logic               s_inc,
   input  logic               s_inm,
   input  logic               s_push,
   input  logic               s_pop,
   input  logic               we3,
   input  logic               wez,
   input  logic               wec,
   input  logic [2:0]         op,
   output logic [5:0]         opcode,
   output logic               z,
   output logic               c,
   output logic               stk_ovf,
   output logic               stk_unf
);

   logic [PW-1:0] pc;
   logic [PW-1:0] pc_inc;
   logic [PW-1:0] pc_next;
   logic [PW-1:0] tgt;
   logic [3:0]    ra1;
   logic [3:0]    ra2;
   logic [3:0]    wa3;
   logic [3:0]    rb_addr;
   logic [7:0]    imm;
   logic [DW-1:0] rf [NREGS];
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] result;
   logic [DW:0]   alu_ext;
   logic          stk_push;
   logic          stk_pop;
   logic [PW-1:0] stk_top;
   logic          stk_full;
   logic          stk_empty;

   assign ra1    = instr[RA1_LSB +: 4];
   assign ra2    = instr[RA2_LSB +: 4];
   assign wa3    = instr[WA3_LSB +: 4];
   assign imm    = instr[IMM_LSB +: 8];
   assign tgt    = instr[PW-1:0];
   assign opcode = instr[OPC_LSB +: 6];

   // Register file: two asynchronous reads, one synchronous write, r0 reads as zero.
   // In immediate mode port B reads the destination so "rX = imm op rX" is possible.
   assign rb_addr = s_inm ? wa3 : ra2;
   assign rd1     = (ra1 == 4'd0)     ? '0 : rf[ra1];
   assign rd2     = (rb_addr == 4'd0) ? '0 : rf[rb_addr];

   always_ff @(posedge clk) begin
      if (we3 && (wa3 != 4'd0))
         rf[wa3] <= result;
   end

   // ALU: one extra bit carries the add carry-out / subtract no-borrow;
   // every other operation leaves it at 0.
   assign alu_a = s_inm ? DW'(imm) : rd1;

   always_comb begin
      alu_ext = '0;
      case (op)
         ALU_PASSA: alu_ext = {1'b0, alu_a};
         ALU_NOTA:  alu_ext = {1'b0, ~alu_a};
         ALU_ADD:   alu_ext = {1'b0, alu_a} + {1'b0, rd2};
         ALU_SUB:   alu_ext = {1'b0, alu_a} + {1'b0, ~rd2} + (DW+1)'(1);
         ALU_AND:   alu_ext = {1'b0, alu_a & rd2};
         ALU_OR:    alu_ext = {1'b0, alu_a | rd2};
         ALU_NEGA:  alu_ext = {1'b0, -alu_a};
         ALU_NEGB:  alu_ext = {1'b0, -rd2};
         default:   alu_ext = '0;
      endcase
   end

   assign result = alu_ext[DW-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         z <= 1'b0;
         c <= 1'b0;
      end else begin
         if (wez) z <= (result == '0);
         if (wec) c <= alu_ext[DW];
      end
   end

   // Program counter and call/return control.
   assign pc_inc   = pc + PW'(1);
   assign stk_push = !s_inc && s_push;
   assign stk_pop  = !s_inc && s_pop;

   always_comb begin
      pc_next = tgt;
      if (s_inc)
         pc_next = pc_inc;
      else if (s_pop)
         pc_next = stk_empty ? pc_inc : stk_top;  // return on empty falls through
   end

   always_ff @(posedge clk) begin
      if (!reset) pc <= '0;
      else        pc <= pc_next;
   end

   assign instr_addr = pc;

   microc_param_stack_ret_stack #(
      .PW    (PW),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (stk_push),
      .pop   (stk_pop),
      .wdata (pc_inc),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty),
      .ovf   (stk_ovf),
      .unf   (stk_unf)
   );

endmodule

// File: tb/tb_microc_param_stack.sv
// Directed bench for microc_param_stack (DW=8, PW=10, DEPTH=8).
module tb_microc_param_stack;

   localparam int DW    = 8;
   localparam int PW    = 10;
   localparam int DEPTH = 8;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [15:0]   instr = '0;
   logic [PW-1:0] instr_addr;
   logic          s_inc = 1'b1;
   logic          s_inm = 1'b0;
   logic          s_push = 1'b0;
   logic          s_pop = 1'b0;
   logic          we3 = 1'b0;
   logic          wez = 1'b0;
   logic          wec = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [5:0]    opcode;
   logic          z;
   logic          c;
   logic          stk_ovf;
   logic          stk_unf;

   microc_param_stack #(.DW(DW), .PW(PW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .instr_addr (instr_addr),
      .s_inc      (s_inc),
      .s_inm      (s_inm),
      .s_push     (s_push),
      .s_pop      (s_pop),
      .we3        (we3),
      .wez        (wez),
      .wec        (wec),
      .op         (op),
      .opcode     (opcode),
      .z          (z),
      .c          (c),
      .stk_ovf    (stk_ovf),
      .stk_unf    (stk_unf)
   );

   // scoreboard
   int checks = 0;
   int failures = 0;
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] cur_pc;
   logic [PW-1:0] exp_ret;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // driver: apply one cycle of control, sample 1 time unit after the edge
   task automatic step(input logic [15:0] i, input logic inc, input logic inm,
                       input logic psh, input logic pp, input logic w3,
                       input logic wz, input logic wc, input logic [2:0] o);
      instr  = i;
      s_inc  = inc;
      s_inm  = inm;
      s_push = psh;
      s_pop  = pp;
      we3    = w3;
      wez    = wz;
      wec    = wc;
      op     = o;
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      step(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic jump(input logic [15:0] t);
      step(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic call(input logic [15:0] t);
      step(t, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic ret();
      step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic swap();
      step(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   // load immediate: rX = imm
   task automatic li(input logic [3:0] r, input logic [7:0] v);
      step({4'h0, v, r}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
   endtask

   // register ALU op: rd = ra op rb, with flag enables
   task automatic alu(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                      input logic w3, input logic wz, input logic wc, input logic [2:0] o);
      step({4'h0, ra, rb, rd}, 1'b1, 1'b0, 1'b0, 1'b0, w3, wz, wc, o);
   endtask

   initial begin
      // reset state
      nop();
      nop();
      check("rst_pc", 32'(instr_addr), 32'h0);
      check("rst_z", 32'(z), 32'h0);
      check("rst_c", 32'(c), 32'h0);
      check("rst_ovf", 32'(stk_ovf), 32'h0);
      check("rst_unf", 32'(stk_unf), 32'h0);
      reset = 1'b1;
      nop();
      check("pc_inc", 32'(instr_addr), 32'h1);

      // opcode passthrough
      instr = 16'hA400;
      #1;
      check("opcode", 32'(opcode), 32'h29);

      // ALU and flags
      li(4'd1, 8'hF0);
      li(4'd2, 8'h20);
      alu(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 3'b010);  // r3 = F0+20 = 0x10
      check("add_c", 32'(c), 32'h1);
      check("add_z", 32'(z), 32'h0);
      alu(4'd2, 4'd2, 4'd0, 1'b0, 1'b1, 1'b1, 3'b011);  // 20-20
      check("sub_eq_z", 32'(z), 32'h1);
      check("sub_eq_c", 32'(c), 32'h1);
      li(4'd4, 8'h10);
      alu(4'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 3'b000);  // pass r1 -> z=0
      check("pass_z", 32'(z), 32'h0);
      alu(4'd3, 4'd4, 4'd0, 1'b0, 1'b1, 1'b1, 3'b011);  // r3-0x10 == 0
      check("add_res_z", 32'(z), 32'h1);
      alu(4'd2, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 3'b011);  // 20-F0 borrows, 0x30
      check("sub_brw_c", 32'(c), 32'h0);
      check("sub_brw_z", 32'(z), 32'h0);
      alu(4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 3'b010);  // c=1
      alu(4'd2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 3'b110);  // -0x20 = E0, c cleared
      check("nega_c", 32'(c), 32'h0);
      check("nega_z", 32'(z), 32'h0);
      alu(4'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 3'b011);  // z held, c=1
      check("hold_z", 32'(z), 32'h0);
      check("hold_c", 32'(c), 32'h1);
      alu(4'd1, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0, 3'b100);  // r5 = F0 & F0
      alu(4'd5, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 3'b011);  // r5 - r1 == 0
      check("and_z", 32'(z), 32'h1);
      // immediate mode: A=imm, B=r[wa3]: 0x10 - r4(0x10) = 0
      alu(4'd2, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 3'b000);  // z=0
      step({4'h0, 8'h10, 4'd4}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011);
      check("imm_sub_z", 32'(z), 32'h1);

      // r0 hardwired to zero
      alu(4'd2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 3'b000);  // z=0
      li(4'd0, 8'h55);
      alu(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 3'b000);  // pass r0
      check("r0_zero", 32'(z), 32'h1);

      // PC wrap
      jump(16'h03FF);
      check("jmp_max", 32'(instr_addr), 32'h3FF);
      nop();
      check("pc_wrap", 32'(instr_addr), 32'h0);

      // call / return
      jump(16'h0005);
      call(16'h0040);
      check("call_pc", 32'(instr_addr), 32'h40);
      ret();
      check("ret_pc", 32'(instr_addr), 32'h6);

      // nested calls fill the stack, then one more overflows
      jump(16'h0100);
      cur_pc = 10'h100;
      for (int k = 0; k < DEPTH; k++) begin
         exp_q.push_back(cur_pc + 10'd1);
         cur_pc = 10'h100 + PW'((k + 1) * 16);
         call(16'(cur_pc));
      end
      check("nest_pc", 32'(instr_addr), 32'(cur_pc));
      check("nest_no_ovf", 32'(stk_ovf), 32'h0);
      call(16'h0200);
      check("ovf_jump", 32'(instr_addr), 32'h200);
      check("ovf_flag", 32'(stk_ovf), 32'h1);
      for (int k = 0; k < DEPTH; k++) begin
         exp_ret = exp_q.pop_back();
         ret();
         check($sformatf("unwind_%0d", k), 32'(instr_addr), 32'(exp_ret));
      end
      check("unwind_unf", 32'(stk_unf), 32'h0);
      check("ovf_sticky", 32'(stk_ovf), 32'h1);

      // pop on empty
      jump(16'h0009);
      ret();
      check("unf_pc", 32'(instr_addr), 32'h00A);
      check("unf_flag", 32'(stk_unf), 32'h1);

      // swap: top=0x30 at PC 0x12
      jump(16'h002F);
      call(16'h0012);
      check("swap_setup", 32'(instr_addr), 32'h012);
      swap();
      check("swap_pc", 32'(instr_addr), 32'h030);
      ret();
      check("swap_top", 32'(instr_addr), 32'h013);
      ret();
      check("swap_depth", 32'(instr_addr), 32'h014);

      // reset mid-call-chain
      call(16'h0080);
      alu(4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 3'b010);  // c=1
      reset = 1'b0;
      nop();
      nop();
      check("rst2_pc", 32'(instr_addr), 32'h0);
      check("rst2_c", 32'(c), 32'h0);
      check("rst2_z", 32'(z), 32'h0);
      check("rst2_ovf", 32'(stk_ovf), 32'h0);
      check("rst2_unf", 32'(stk_unf), 32'h0);
      reset = 1'b1;
      ret();
      check("rst2_empty", 32'(instr_addr), 32'h1);
      check("rst2_unf_set", 32'(stk_unf), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
